mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Load/store sequencer for the LC-3b memory port. It latches the effective address produced by the address adder (MAR) on START. It then drives the memory enable, write-enable and data lanes and waits for the memory ready (R) handshake. It returns the loaded word or byte (sign-extended) with a one-cycle DONE pulse, and flags unaligned word accesses and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 16, max ACCESS cycles without MEM_R before fault (>=1)
ADDR_W, 16, address/data width (LC-3b word)

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only in IDLE
OP  input  2  00=LDB, 01=LDW, 10=STB, 11=STW
ADDR_IN  input  16  effective address from address adder
ST_DATA  input  16  store source register value
MEM_R  input  1  memory ready, valid during ACCESS
MEM_RDATA  input  16  memory read word (both bytes)
MEM_EN  output  1  memory access strobe
MEM_WE  output  2  byte-lane write enables {hi,lo}
MEM_ADDR  output  16  word address {MAR[15:1],1'b0}
MEM_WDATA  output  16  store data
LD_DATA  output  16  load result (MDR)
BUSY  output  1  high in any state but IDLE
DONE  output  1  one-cycle completion pulse
UNALIGNED  output  1  one-cycle pulse, word op with odd address
TIMEOUT  output  1  one-cycle pulse, MEM_R never arrived

Behaviour:
- Asynchronous RESET_N low: state=IDLE, MAR=0, OP reg=0, wait counter=0. All outputs 0, including LD_DATA.
- Reset mid-ACCESS aborts the access immediately. MEM_EN/MEM_WE drop asynchronously. No DONE or fault pulse follows.
- States: IDLE, ACCESS, DONE, FAULT.
- IDLE: BUSY=0, MEM_EN=0, MEM_WE=00. On START=1, latch MAR<=ADDR_IN, OP, WDATA source.
  - If OP is LDW/STW and ADDR_IN[0]=1, go to FAULT(unaligned).
  - Otherwise go to ACCESS. Wait counter is cleared.
- ACCESS: MEM_EN=1, MEM_ADDR={MAR[15:1],0}.
  - MEM_WE: STW=11; STB=10 if MAR[0] else 01; loads=00.
  - MEM_WDATA: STW=ST_DATA; STB={ST_DATA[7:0],ST_DATA[7:0]}; loads=0.
  - MEM_R=1: capture the load result and go to DONE.
    - LDW: LD_DATA=MEM_RDATA.
    - LDB: LD_DATA = sign-extended MEM_RDATA[15:8] if MAR[0], else sign-extended [7:0].
    - Stores leave LD_DATA unchanged.
  - MEM_R=0: counter++. When counter reaches TIMEOUT_CYCLES-1 with MEM_R still 0, go to FAULT(timeout) next cycle. MEM_R in the same cycle wins over timeout.
- DONE: DONE=1, BUSY=1, MEM_EN=0. Next state is IDLE.
- FAULT: exactly one of UNALIGNED/TIMEOUT=1, BUSY=1, MEM_EN=0, LD_DATA unchanged. Next state is IDLE.
- START outside IDLE is ignored; there is no queuing. START may be reasserted in the cycle after DONE/FAULT, which is IDLE.
- Latency: START at edge n, ACCESS during cycle n+1. With MEM_R in the first ACCESS cycle, DONE is high during n+2. Minimum turnaround is 3 cycles per access.
- Outputs are registered state decodes. MEM_* depend only on state and latched registers, not directly on inputs.
- LD_DATA holds until the next successful load or reset.
- MEM_ADDR wrap: MAR=FFFF byte op gives MEM_ADDR=FFFE, high lane; no wrap logic.

Test Plan:
- LDW aligned: ADDR_IN=0x3000, MEM_R high in first ACCESS cycle, MEM_RDATA=0xBEEF. Expect MEM_ADDR=0x3000, MEM_WE=00, DONE at START+2, LD_DATA=0xBEEF.
- LDB odd/even sign-extend: ADDR_IN=0x3001, MEM_RDATA=0x80FF gives LD_DATA=0xFF80. ADDR_IN=0x3000 gives LD_DATA=0xFFFF. With MEM_RDATA=0x7F00 and ADDR 0x3001, LD_DATA=0x007F.
- STB/STW lanes: STB ADDR=0x4003, ST_DATA=0x12AB gives MEM_WE=10, MEM_WDATA=0xABAB, MEM_ADDR=0x4002. STW ADDR=0x4002 gives MEM_WE=11, MEM_WDATA=0x12AB. LD_DATA unchanged in both cases.
- Unaligned: LDW ADDR_IN=0x3001 gives UNALIGNED pulse at START+1, MEM_EN never high, no DONE, BUSY low at START+2.
- Timeout/wait: TIMEOUT_CYCLES=4 with MEM_R held 0 gives MEM_EN high for 4 cycles, then a TIMEOUT pulse, then IDLE. MEM_R arriving in the 4th ACCESS cycle gives DONE, not TIMEOUT. START pulses during BUSY are ignored.
- Reset mid-access: drop RESET_N during ACCESS asynchronously. All outputs are 0 immediately, and no DONE follows after release.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// LC-3b memory port load/store sequencer.
// On START the MAR, opcode and store data are latched. The block then strobes
// the memory until MEM_R arrives and returns the loaded word or sign-extended
// byte with a one-cycle DONE pulse. Unaligned word accesses and missing
// ready handshakes end in a one-cycle fault pulse instead.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [1:0]        OP,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic [ADDR_W-1:0] ST_DATA,
  input  logic              MEM_R,
  input  logic [ADDR_W-1:0] MEM_RDATA,
  output logic              MEM_EN,
  output logic [1:0]        MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [ADDR_W-1:0] MEM_WDATA,
  output logic [ADDR_W-1:0] LD_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              UNALIGNED,
  output logic              TIMEOUT
);

  // The wait counter only ever needs to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  // OP[1] selects store, OP[0] selects word width.
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] mar_q,   mar_d;
  logic [1:0]        op_q,    op_d;
  logic [ADDR_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [ADDR_W-1:0] ld_q,    ld_d;
  logic              flt_to_q, flt_to_d;  // 1: timeout fault, 0: unaligned fault

  // Select the addressed byte lane and sign-extend it to a full word.
  function automatic logic [ADDR_W-1:0] byte_sext(input logic hi_lane,
                                                  input logic [ADDR_W-1:0] word);
    logic [7:0] b;
    b = hi_lane ? word[15:8] : word[7:0];
    return {{(ADDR_W-8){b[7]}}, b};
  endfunction

  // Next-state and datapath-capture logic.
  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    op_d     = op_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ld_d     = ld_q;
    flt_to_d = flt_to_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          mar_d   = ADDR_IN;
          op_d    = OP;
          wdata_d = ST_DATA;
          cnt_d   = '0;
          if (OP[0] && ADDR_IN[0]) begin
            state_d  = ST_FAULT;
            flt_to_d = 1'b0;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // A ready in the last allowed cycle still completes the access.
        if (MEM_R) begin
          if (!op_q[1]) begin
            ld_d = op_q[0] ? MEM_RDATA : byte_sext(mar_q[0], MEM_RDATA);
          end
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_FAULT;
          flt_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and latched operand registers; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      mar_q    <= '0;
      op_q     <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      ld_q     <= '0;
      flt_to_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mar_q    <= mar_d;
      op_q     <= op_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      ld_q     <= ld_d;
      flt_to_q <= flt_to_d;
    end
  end

  // Output decode from registered state only, so the memory side never sees
  // a combinational path from the request inputs.
  always_comb begin
    MEM_EN    = (state_q == ST_ACCESS);
    MEM_ADDR  = {mar_q[ADDR_W-1:1], 1'b0};
    MEM_WE    = 2'b00;
    MEM_WDATA = '0;
    if (MEM_EN && op_q[1]) begin
      if (op_q[0]) begin
        MEM_WE    = 2'b11;
        MEM_WDATA = wdata_q;
      end else begin
        MEM_WE    = mar_q[0] ? 2'b10 : 2'b01;
        MEM_WDATA = ADDR_W'({wdata_q[7:0], wdata_q[7:0]});
      end
    end
    LD_DATA   = ld_q;
    BUSY      = (state_q != ST_IDLE);
    DONE      = (state_q == ST_DONE);
    UNALIGNED = (state_q == ST_FAULT) && !flt_to_q;
    TIMEOUT   = (state_q == ST_FAULT) &&  flt_to_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: directed cases followed by randomized
// transactions, each checked against a transaction-level expectation.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic [1:0]  OP = 2'b00;
  logic [15:0] ADDR_IN = '0;
  logic [15:0] ST_DATA = '0;
  logic        MEM_R = 1'b0;
  logic [15:0] MEM_RDATA = '0;
  logic        MEM_EN;
  logic [1:0]  MEM_WE;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_WDATA;
  logic [15:0] LD_DATA;
  logic        BUSY;
  logic        DONE;
  logic        UNALIGNED;
  logic        TIMEOUT;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_ld = 16'h0000;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(16)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP(OP), .ADDR_IN(ADDR_IN),
    .ST_DATA(ST_DATA), .MEM_R(MEM_R), .MEM_RDATA(MEM_RDATA), .MEM_EN(MEM_EN),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .LD_DATA(LD_DATA), .BUSY(BUSY), .DONE(DONE), .UNALIGNED(UNALIGNED),
    .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full transaction. wait_cyc = number of ACCESS cycles with MEM_R low
  // before it rises; wait_cyc >= TO means the memory never answers in time.
  task automatic do_txn(input logic [1:0] op, input logic [15:0] addr,
                        input logic [15:0] sdata, input logic [15:0] rdata,
                        input int wait_cyc, input bit noise);
    bit is_store, is_word;
    logic [1:0]  we_exp;
    logic [15:0] wd_exp, bval;
    is_store = op[1];
    is_word  = op[0];
    if (!is_store)     we_exp = 2'b00;
    else if (is_word)  we_exp = 2'b11;
    else               we_exp = addr[0] ? 2'b10 : 2'b01;
    if (!is_store)     wd_exp = 16'h0000;
    else if (is_word)  wd_exp = sdata;
    else               wd_exp = (sdata & 16'h00FF) * 16'd257;

    START = 1'b1; OP = op; ADDR_IN = addr; ST_DATA = sdata; MEM_R = 1'b0;
    tick();
    START = 1'b0;
    ADDR_IN = 16'($urandom);
    OP = 2'($urandom);
    if (is_word && addr[0]) begin
      chk("unal_pulse", UNALIGNED, 1);
      chk("unal_en", MEM_EN, 0);
      chk("unal_done", DONE, 0);
      chk("unal_busy", BUSY, 1);
      tick();
      chk("unal_idle_busy", BUSY, 0);
      chk("unal_idle_pulse", UNALIGNED, 0);
      chk("unal_ld", LD_DATA, exp_ld);
      return;
    end
    for (int i = 0; i < TO; i++) begin
      chk("acc_en", MEM_EN, 1);
      chk("acc_busy", BUSY, 1);
      chk("acc_we", MEM_WE, we_exp);
      chk("acc_addr", MEM_ADDR, addr & 16'hFFFE);
      chk("acc_wdata", MEM_WDATA, wd_exp);
      chk("acc_done", DONE, 0);
      START = noise ? 1'($urandom) : 1'b0;
      if (i == wait_cyc) begin
        MEM_R = 1'b1;
        MEM_RDATA = rdata;
      end else begin
        MEM_R = 1'b0;
        MEM_RDATA = 16'($urandom);
      end
      tick();
      MEM_R = 1'b0;
      START = 1'b0;
      if (i == wait_cyc) begin
        if (!is_store) begin
          if (is_word) exp_ld = rdata;
          else begin
            bval = addr[0] ? (rdata >> 8) : (rdata & 16'h00FF);
            exp_ld = (bval >= 16'd128) ? bval + 16'hFF00 : bval;
          end
        end
        chk("done_pulse", DONE, 1);
        chk("done_to", TIMEOUT, 0);
        chk("done_en", MEM_EN, 0);
        chk("done_busy", BUSY, 1);
        chk("done_ld", LD_DATA, exp_ld);
        break;
      end else if (i == TO - 1) begin
        chk("to_pulse", TIMEOUT, 1);
        chk("to_unal", UNALIGNED, 0);
        chk("to_done", DONE, 0);
        chk("to_en", MEM_EN, 0);
        chk("to_ld", LD_DATA, exp_ld);
      end
    end
    tick();
    chk("idle_busy", BUSY, 0);
    chk("idle_done", DONE, 0);
    chk("idle_to", TIMEOUT, 0);
    chk("idle_en", MEM_EN, 0);
    chk("idle_ld", LD_DATA, exp_ld);
  endtask

  initial begin
    #2;
    chk("rst_en", MEM_EN, 0);
    chk("rst_we", MEM_WE, 0);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_wdata", MEM_WDATA, 0);
    chk("rst_ld", LD_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_flags", {DONE, UNALIGNED, TIMEOUT}, 0);
    #10 RESET_N = 1'b1;
    tick();

    do_txn(2'b01, 16'h3000, 16'h0000, 16'hBEEF, 0, 0);
    do_txn(2'b00, 16'h3001, 16'h0000, 16'h80FF, 0, 0);
    do_txn(2'b00, 16'h3000, 16'h0000, 16'h80FF, 0, 0);
    do_txn(2'b00, 16'h3001, 16'h0000, 16'h7F00, 0, 0);
    do_txn(2'b10, 16'h4003, 16'h12AB, 16'h5555, 0, 0);
    do_txn(2'b11, 16'h4002, 16'h12AB, 16'h5555, 1, 0);
    do_txn(2'b01, 16'h3001, 16'h0000, 16'h1234, 0, 0);
    do_txn(2'b11, 16'h3003, 16'h9999, 16'h1234, 0, 0);
    do_txn(2'b01, 16'h3000, 16'h0000, 16'h1111, 10, 1);
    do_txn(2'b01, 16'h3000, 16'h0000, 16'h2222, TO - 1, 1);
    do_txn(2'b10, 16'hFFFF, 16'h00C3, 16'h0000, 0, 0);
    do_txn(2'b00, 16'hFFFF, 16'h0000, 16'hA512, 2, 1);

    // Reset in the middle of an access.
    START = 1'b1; OP = 2'b01; ADDR_IN = 16'h3000;
    tick();
    START = 1'b0;
    chk("mid_en_before", MEM_EN, 1);
    MEM_R = 1'b1; MEM_RDATA = 16'hDEAD;
    #2 RESET_N = 1'b0;
    #1;
    exp_ld = 16'h0000;
    chk("mid_en", MEM_EN, 0);
    chk("mid_we", MEM_WE, 0);
    chk("mid_busy", BUSY, 0);
    chk("mid_ld", LD_DATA, 0);
    chk("mid_flags", {DONE, UNALIGNED, TIMEOUT}, 0);
    #3 RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_done", DONE, 0);
      chk("post_rst_busy", BUSY, 0);
      chk("post_rst_ld", LD_DATA, 0);
    end
    MEM_R = 1'b0;

    for (int n = 0; n < 200; n++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      do_txn(2'($urandom), a, 16'($urandom), 16'($urandom),
             int'($urandom_range(0, TO + 1)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
